// File: rtl/icache_miss_controller.sv
// rtl/icache_miss_controller.sv - I-cache miss MSHR file with next-line prefetch and memory port issue
module icache_miss_controller #(
  parameter int NUM_MSHR       = 4,
  parameter int PREFETCH_DEPTH = 1,
  parameter int LINE_BYTES     = 8,
  parameter int MEM_TAG_BITS   = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    miss_valid_i,
  input  logic [31:0]             miss_addr_i,
  output logic                    miss_ready_o,
  input  logic                    restore_valid_i,
  output logic                    mem_req_valid_o,
  output logic [31:0]             mem_req_addr_o,
  input  logic                    mem_req_gnt_i,
  input  logic [MEM_TAG_BITS-1:0] mem_transaction_tag_i,
  input  logic [MEM_TAG_BITS-1:0] mem_resp_tag_i,
  input  logic [63:0]             mem_resp_data_i,
  output logic                    fill_valid_o,
  output logic [31:0]             fill_addr_o,
  output logic [63:0]             fill_data_o,
  output logic [NUM_MSHR-1:0]     mshr_busy_o
);
  localparam int OFF = $clog2(LINE_BYTES);
  localparam int LW  = 32 - OFF;
  localparam int IW  = $clog2(NUM_MSHR);
  localparam int SW  = IW + 1;

  logic [NUM_MSHR-1:0]     valid_q, valid_d, issued_q, issued_d, squashed_q, squashed_d;
  logic [LW-1:0]           line_q [NUM_MSHR];
  logic [LW-1:0]           line_d [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0] tag_q  [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0] tag_d  [NUM_MSHR];
  logic [SW-1:0]           seq_q  [NUM_MSHR];
  logic [SW-1:0]           seq_d  [NUM_MSHR];
  logic [SW-1:0]           alloc_seq_q, alloc_seq_d;
  logic                    fill_valid_q, fill_valid_d;
  logic [31:0]             fill_addr_q, fill_addr_d;
  logic [63:0]             fill_data_q, fill_data_d;

  logic [NUM_MSHR-1:0] resp_hit, avail, alloc;
  logic [LW-1:0]       alloc_line [NUM_MSHR];
  logic [SW-1:0]       alloc_seqn [NUM_MSHR];
  logic [LW-1:0]       miss_line, cand_line;
  logic                demand_match, miss_ready, present, placed, req_found, grant;
  logic [IW-1:0]       req_idx;
  logic [SW-1:0]       age_diff, seq_n;
  logic                unused_offset;

  assign unused_offset = ^miss_addr_i[OFF-1:0];
  assign miss_line     = miss_addr_i[31:OFF];

  // Lookup: response match, merge match, readiness and oldest issuable entry.
  always_comb begin
    resp_hit     = '0;
    demand_match = 1'b0;
    req_found    = 1'b0;
    req_idx      = '0;
    age_diff     = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (valid_q[i] && issued_q[i] && (mem_resp_tag_i != '0) && (tag_q[i] == mem_resp_tag_i))
        resp_hit[i] = 1'b1;
      if (valid_q[i] && !squashed_q[i] && (line_q[i] == miss_line))
        demand_match = 1'b1;
      // Ages are wrapping allocation sequence numbers; unissued entries never span more than NUM_MSHR.
      age_diff = seq_q[req_idx] - seq_q[i];
      if (valid_q[i] && !issued_q[i] && !squashed_q[i] &&
          (!req_found || (!age_diff[SW-1] && (age_diff != '0)))) begin
        req_found = 1'b1;
        req_idx   = IW'(i);
      end
    end
    miss_ready      = (|(~valid_q | resp_hit)) || demand_match;
    mem_req_valid_o = req_found;
    mem_req_addr_o  = req_found ? {line_q[req_idx], {OFF{1'b0}}} : 32'd0;
    grant           = req_found && mem_req_gnt_i && (mem_transaction_tag_i != '0);
  end

  // Allocation: demand line first, then sequential prefetch lines into remaining free slots.
  always_comb begin
    avail = ~valid_q | resp_hit;
    alloc = '0;
    seq_n = alloc_seq_q;
    cand_line = miss_line;
    present = 1'b0;
    placed  = 1'b0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      alloc_line[i] = '0;
      alloc_seqn[i] = '0;
    end
    if (miss_valid_i && miss_ready && !restore_valid_i) begin
      for (int k = 0; k <= PREFETCH_DEPTH; k++) begin
        cand_line = miss_line + LW'(k);
        present   = 1'b0;
        placed    = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++)
          if (valid_q[i] && !squashed_q[i] && (line_q[i] == cand_line)) present = 1'b1;
        if (!present) begin
          for (int i = 0; i < NUM_MSHR; i++) begin
            if (!placed && avail[i]) begin
              placed        = 1'b1;
              avail[i]      = 1'b0;
              alloc[i]      = 1'b1;
              alloc_line[i] = cand_line;
              alloc_seqn[i] = seq_n;
              seq_n         = seq_n + 1'b1;
            end
          end
        end
      end
    end
    alloc_seq_d = seq_n;
  end

  // Per-entry next state: grant, then restore, then response free, then allocation.
  always_comb begin
    valid_d      = valid_q;
    issued_d     = issued_q;
    squashed_d   = squashed_q;
    line_d       = line_q;
    tag_d        = tag_q;
    seq_d        = seq_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (grant && (req_idx == IW'(i))) begin
        issued_d[i] = 1'b1;
        tag_d[i]    = mem_transaction_tag_i;
      end
      if (restore_valid_i && valid_q[i]) begin
        if (issued_d[i]) squashed_d[i] = 1'b1;
        else             valid_d[i]    = 1'b0;
      end
      if (resp_hit[i]) begin
        valid_d[i]    = 1'b0;
        issued_d[i]   = 1'b0;
        squashed_d[i] = 1'b0;
        if (!squashed_q[i] && !restore_valid_i) begin
          fill_valid_d = 1'b1;
          fill_addr_d  = {line_q[i], {OFF{1'b0}}};
          fill_data_d  = mem_resp_data_i;
        end
      end
      if (alloc[i]) begin
        valid_d[i]    = 1'b1;
        issued_d[i]   = 1'b0;
        squashed_d[i] = 1'b0;
        line_d[i]     = alloc_line[i];
        seq_d[i]      = alloc_seqn[i];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q      <= '0;
      issued_q     <= '0;
      squashed_q   <= '0;
      alloc_seq_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      for (int i = 0; i < NUM_MSHR; i++) begin
        line_q[i] <= '0;
        tag_q[i]  <= '0;
        seq_q[i]  <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      issued_q     <= issued_d;
      squashed_q   <= squashed_d;
      alloc_seq_q  <= alloc_seq_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      for (int i = 0; i < NUM_MSHR; i++) begin
        line_q[i] <= line_d[i];
        tag_q[i]  <= tag_d[i];
        seq_q[i]  <= seq_d[i];
      end
    end
  end

  assign miss_ready_o = miss_ready;
  assign fill_valid_o = fill_valid_q;
  assign fill_addr_o  = fill_addr_q;
  assign fill_data_o  = fill_data_q;
  assign mshr_busy_o  = valid_q;
endmodule

// File: tb/tb_icache_miss_controller.sv
// tb/tb_icache_miss_controller.sv - scenario tasks with a fill scoreboard for icache_miss_controller
module tb_icache_miss_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid, miss_ready, restore_valid;
  logic [31:0] miss_addr;
  logic        mem_req_valid, mem_req_gnt;
  logic [31:0] mem_req_addr;
  logic [3:0]  ttag, rtag;
  logic [63:0] rdata;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic [63:0] fill_data;
  logic [3:0]  busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } fill_t;
  fill_t exp_q[$];

  always #5 clk = ~clk;

  icache_miss_controller dut (
    .clock_i(clk), .reset_i(reset),
    .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
    .restore_valid_i(restore_valid),
    .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr), .mem_req_gnt_i(mem_req_gnt),
    .mem_transaction_tag_i(ttag), .mem_resp_tag_i(rtag), .mem_resp_data_i(rdata),
    .fill_valid_o(fill_valid), .fill_addr_o(fill_addr), .fill_data_o(fill_data),
    .mshr_busy_o(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    miss_valid = 1'b0; miss_addr = '0; restore_valid = 1'b0;
    mem_req_gnt = 1'b0; ttag = '0; rtag = '0; rdata = '0;
  endtask

  task automatic respond(input logic [3:0] tag, input logic [63:0] data, input logic [31:0] addr, input bit expect_fill);
    rtag = tag; rdata = data;
    if (expect_fill) exp_q.push_back({addr, data});
  endtask

  // Scoreboard: every fill pulse must match the oldest expected fill.
  always @(negedge clk) begin
    fill_t e;
    if (fill_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL fill_unexpected: got addr=%h data=%h, required no fill", fill_addr, fill_data);
      end else begin
        e = exp_q.pop_front();
        if (fill_addr !== e.addr || fill_data !== e.data) begin
          fails++; $display("FAIL fill_match: got addr=%h data=%h, required addr=%h data=%h", fill_addr, fill_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    idle(); reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    tests++; if (busy !== 4'b0000) begin fails++; $display("FAIL reset_busy: got %b required 0000", busy); end
    tests++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_req: got v=%b a=%h required v=0 a=0", mem_req_valid, mem_req_addr); end
    tests++; if (fill_valid !== 1'b0 || fill_addr !== 32'h0 || fill_data !== 64'h0) begin fails++; $display("FAIL reset_fill: got v=%b a=%h d=%h required zeros", fill_valid, fill_addr, fill_data); end
    tests++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", miss_ready); end
  endtask

  task automatic test_single_miss();
    miss_valid = 1'b1; miss_addr = 32'h1004; #1;
    tests++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b required 1", miss_ready); end
    cyc(); idle();
    tests++; if (busy !== 4'b0011) begin fails++; $display("FAIL single_alloc: got %b required 0011", busy); end
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin fails++; $display("FAIL single_req: got v=%b a=%h required v=1 a=00001000", mem_req_valid, mem_req_addr); end
    mem_req_gnt = 1'b1; ttag = 4'd3;
    cyc(); idle();
    tests++; if (mem_req_addr !== 32'h1008) begin fails++; $display("FAIL single_next_req: got %h required 00001008", mem_req_addr); end
    respond(4'd3, 64'hDEAD, 32'h1000, 1'b1);
    cyc(); idle();
    tests++; if (fill_valid !== 1'b1 || fill_addr !== 32'h1000 || fill_data !== 64'hDEAD) begin fails++; $display("FAIL single_fill: got v=%b a=%h d=%h required v=1 a=00001000 d=dead", fill_valid, fill_addr, fill_data); end
    tests++; if (busy !== 4'b0010) begin fails++; $display("FAIL single_free: got %b required 0010", busy); end
    mem_req_gnt = 1'b1; ttag = 4'd4;
    cyc(); idle();
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL single_all_issued: got %b required 0", mem_req_valid); end
    respond(4'd4, 64'hBEEF, 32'h1008, 1'b1);
    cyc(); idle();
    tests++; if (busy !== 4'b0000) begin fails++; $display("FAIL single_drained: got %b required 0000", busy); end
    cyc();
  endtask

  task automatic test_rejected_grant();
    miss_valid = 1'b1; miss_addr = 32'h1000;
    cyc(); idle();
    for (int n = 0; n < 3; n++) begin
      mem_req_gnt = 1'b1; ttag = 4'd0;
      cyc();
      tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin fails++; $display("FAIL reject_hold%0d: got v=%b a=%h required v=1 a=00001000", n, mem_req_valid, mem_req_addr); end
    end
    mem_req_gnt = 1'b1; ttag = 4'd5;
    cyc(); idle();
    tests++; if (mem_req_addr !== 32'h1008) begin fails++; $display("FAIL reject_then_issue: got %h required 00001008", mem_req_addr); end
    mem_req_gnt = 1'b1; ttag = 4'd6;
    cyc(); idle();
    respond(4'd5, 64'h55, 32'h1000, 1'b1);
    cyc();
    respond(4'd6, 64'h66, 32'h1008, 1'b1);
    cyc(); idle(); cyc();
    tests++; if (busy !== 4'b0000) begin fails++; $display("FAIL reject_drained: got %b required 0000", busy); end
  endtask

  task automatic test_full_and_restore();
    miss_valid = 1'b1; miss_addr = 32'h1000;
    cyc();
    miss_addr = 32'h1100;
    cyc(); idle();
    tests++; if (busy !== 4'b1111) begin fails++; $display("FAIL full_busy: got %b required 1111", busy); end
    miss_valid = 1'b1; miss_addr = 32'h2000; #1;
    tests++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL full_ready_new: got %b required 0", miss_ready); end
    miss_addr = 32'h1108; #1;
    tests++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL full_ready_merge: got %b required 1", miss_ready); end
    idle(); #1;
    tests++; if (mem_req_addr !== 32'h1000) begin fails++; $display("FAIL full_oldest: got %h required 00001000", mem_req_addr); end
    mem_req_gnt = 1'b1; ttag = 4'd1;
    cyc();
    tests++; if (mem_req_addr !== 32'h1008) begin fails++; $display("FAIL full_second: got %h required 00001008", mem_req_addr); end
    ttag = 4'd2;
    cyc(); idle();
    tests++; if (mem_req_addr !== 32'h1100) begin fails++; $display("FAIL full_third: got %h required 00001100", mem_req_addr); end
    restore_valid = 1'b1;
    cyc(); idle();
    tests++; if (busy !== 4'b0011 || mem_req_valid !== 1'b0) begin fails++; $display("FAIL restore_state: got busy=%b v=%b required busy=0011 v=0", busy, mem_req_valid); end
    respond(4'd1, 64'h11, 32'h1000, 1'b0);
    cyc();
    respond(4'd2, 64'h22, 32'h1008, 1'b0);
    cyc(); idle();
    tests++; if (fill_valid !== 1'b0 || busy !== 4'b0000) begin fails++; $display("FAIL restore_drain: got fill=%b busy=%b required fill=0 busy=0000", fill_valid, busy); end
    cyc();
  endtask

  task automatic test_same_cycle();
    miss_valid = 1'b1; miss_addr = 32'h3000;
    cyc(); idle();
    mem_req_gnt = 1'b1; ttag = 4'd1;
    cyc(); idle();
    respond(4'd1, 64'hAAAA, 32'h3000, 1'b1);
    miss_valid = 1'b1; miss_addr = 32'h3000; #1;
    tests++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL merge_ready: got %b required 1", miss_ready); end
    cyc(); idle();
    tests++; if (busy !== 4'b0010) begin fails++; $display("FAIL merge_no_realloc: got %b required 0010", busy); end
    mem_req_gnt = 1'b1; ttag = 4'd2;
    cyc(); idle();
    respond(4'd2, 64'hBBBB, 32'h3008, 1'b0);
    restore_valid = 1'b1;
    cyc(); idle();
    tests++; if (fill_valid !== 1'b0 || busy !== 4'b0000) begin fails++; $display("FAIL restore_resp: got fill=%b busy=%b required fill=0 busy=0000", fill_valid, busy); end
    // Grant during restore: entry drains silently; same line then reallocates fresh.
    miss_valid = 1'b1; miss_addr = 32'h4000;
    cyc(); idle();
    mem_req_gnt = 1'b1; ttag = 4'd7; restore_valid = 1'b1;
    cyc(); idle();
    tests++; if (busy !== 4'b0001 || mem_req_valid !== 1'b0) begin fails++; $display("FAIL restore_grant: got busy=%b v=%b required busy=0001 v=0", busy, mem_req_valid); end
    miss_valid = 1'b1; miss_addr = 32'h4000;
    cyc(); idle();
    tests++; if (busy !== 4'b0111 || mem_req_addr !== 32'h4000) begin fails++; $display("FAIL squashed_realloc: got busy=%b a=%h required busy=0111 a=00004000", busy, mem_req_addr); end
    mem_req_gnt = 1'b1; ttag = 4'd8;
    cyc();
    ttag = 4'd9;
    cyc(); idle();
    respond(4'd7, 64'h47, 32'h4000, 1'b0);
    cyc(); idle();
    tests++; if (fill_valid !== 1'b0 || busy !== 4'b0110) begin fails++; $display("FAIL squashed_silent: got fill=%b busy=%b required fill=0 busy=0110", fill_valid, busy); end
    respond(4'd8, 64'h48, 32'h4000, 1'b1);
    cyc();
    respond(4'd9, 64'h49, 32'h4008, 1'b1);
    cyc(); idle(); cyc();
    tests++; if (busy !== 4'b0000) begin fails++; $display("FAIL same_drained: got %b required 0000", busy); end
  endtask

  task automatic test_reset_midflight();
    miss_valid = 1'b1; miss_addr = 32'h5000;
    cyc();
    miss_addr = 32'h6000;
    cyc(); idle();
    for (int n = 1; n <= 3; n++) begin
      mem_req_gnt = 1'b1; ttag = 4'(n);
      cyc();
    end
    idle();
    tests++; if (busy !== 4'b1111 || mem_req_addr !== 32'h6008) begin fails++; $display("FAIL mid_state: got busy=%b a=%h required busy=1111 a=00006008", busy, mem_req_addr); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++; if (busy !== 4'b0000 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || fill_valid !== 1'b0 || miss_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset: got busy=%b v=%b a=%h fill=%b rdy=%b required 0000/0/0/0/1", busy, mem_req_valid, mem_req_addr, fill_valid, miss_ready);
    end
    for (int n = 1; n <= 3; n++) begin
      respond(4'(n), 64'(n), 32'h0, 1'b0);
      cyc();
    end
    idle(); cyc();
    tests++; if (busy !== 4'b0000 || fill_valid !== 1'b0) begin fails++; $display("FAIL mid_stale: got busy=%b fill=%b required 0000/0", busy, fill_valid); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_rejected_grant();
    test_full_and_restore();
    test_same_cycle();
    test_reset_midflight();
    cyc();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL fill_missing: got %0d pending fills required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache_miss_controller.md
Name: icache_miss_controller

Overview:
- Sequences I-cache line fills for the fetch stage: tracks outstanding misses in a small MSHR file, issues next-line prefetches, and drives the shared instruction-memory request port.
- Sits between the I-cache (miss requests in, fills out) and the memory port, which a higher-level arbiter grants.
- Squashes wrong-path traffic on a branch-stack restore.

Parameters:
- NUM_MSHR, 4, number of outstanding line entries (power of two, ≥2).
- PREFETCH_DEPTH, 1, sequential lines prefetched after a demand miss (0 disables prefetch).
- LINE_BYTES, 8, cache line size; line address = addr[31:3].
- MEM_TAG_BITS, 4, memory transaction tag width; tag 0 means "no transaction".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- miss_valid  in  1  I-cache demand miss this cycle
- miss_addr  in  32  missing PC; low 3 bits ignored
- miss_ready  out  1  a demand miss can be accepted this cycle
- restore_valid  in  1  branch-stack restore; squash all in-flight lines
- mem_req_valid  out  1  request to memory arbiter
- mem_req_addr  out  32  line-aligned request address
- mem_req_gnt  in  1  arbiter granted the port this cycle
- mem_transaction_tag  in  MEM_TAG_BITS  tag returned same cycle as a granted request; 0 = rejected
- mem_resp_tag  in  MEM_TAG_BITS  tag of returning data; 0 = none
- mem_resp_data  in  64  returning line data
- fill_valid  out  1  write line into I-cache
- fill_addr  out  32  line-aligned fill address
- fill_data  out  64  fill data
- mshr_busy  out  NUM_MSHR  per-entry valid, for debug and the bench

Behaviour:
- Entry fields: valid, issued, squashed, line_addr[28:0], tag, age. The age order is a rotating allocation index.
- Reset: all entries invalid. mem_req_valid=0, fill_valid=0, mem_req_addr=0, fill_addr=0, fill_data=0, miss_ready=1.
- miss_ready is combinational: 1 iff at least one entry is free, or the miss line matches a valid, unsquashed entry.
- Allocation on miss_valid && miss_ready && !restore_valid:
  - If the line matches a valid unsquashed entry, merge: no new entry.
  - Otherwise allocate the lowest free index.
  - Then, for k=1..PREFETCH_DEPTH, allocate line+k if a free entry remains and the line is not already present. Prefetches never block miss_ready.
  - Free counts are evaluated after this cycle's frees.
- Issue:
  - mem_req_valid=1 iff any valid, unissued, unsquashed entry exists. mem_req_addr is the oldest such entry's line<<3.
  - mem_req_gnt && mem_transaction_tag≠0: mark the entry issued, store the tag.
  - Grant with tag 0, or no grant: hold and retry next cycle with the same address.
  - At most one issue per cycle. The issue decision is combinational from the current state; the state update is registered.
- Response:
  - When mem_resp_tag≠0 matches an issued entry's tag, free that entry at the clock edge.
  - If that entry is not squashed, assert next cycle: fill_valid=1, fill_addr=line<<3, fill_data=mem_resp_data (latency 1).
  - A squashed entry is freed silently with fill_valid=0.
  - An unmatched nonzero resp tag is ignored.
  - fill_valid is a 1-cycle pulse; at most one fill per cycle.
- restore_valid (highest priority over allocation that cycle):
  - Unissued entries are invalidated immediately.
  - Issued entries are marked squashed, stay valid until their response, and occupy a slot meanwhile.
  - A response arriving in the same cycle as restore_valid is treated as squashed (no fill).
  - miss_valid in the restore cycle is ignored.
  - A grant in the restore cycle for an entry being invalidated: the tag is recorded and the entry becomes issued+squashed, so the returning data is drained without a fill.
- Simultaneous response-free and miss to the same line: treated as a merge (fill covers it); no new entry.
- Merge never matches squashed entries; a new miss to a squashed line allocates a fresh entry.
- Tags are unique in memory, so no two valid entries hold the same tag.
- Reset mid-operation clears all state; later responses carrying old tags are ignored as unmatched.

Test Plan:
- Single miss, PREFETCH_DEPTH=1: miss 0x1004 → entries for lines 0x1000 and 0x1008. Next cycle: mem_req_addr=0x1000. Grant tag 3; resp tag 3 data 0xDEAD → the following cycle fill_valid=1, fill_addr=0x1000, fill_data=0xDEAD. Then 0x1008 is issued.
- Rejected grant: mem_req_gnt=1, tag=0 for 3 cycles → mem_req_addr stays 0x1000, no entry issued. Tag 5 on the 4th cycle → issued.
- Full: 4 distinct unissued misses fill the MSHRs → miss_ready=0 for new line 0x2000, while a miss to an in-flight line still gives miss_ready=1 (merge).
- Restore: 2 issued (tags 1, 2) plus 2 unissued entries, assert restore_valid → mshr_busy=0b0011 and mem_req_valid=0. Responses for tags 1 and 2 → no fill_valid, mshr_busy→0.
- Same-cycle events: response tag 1 for line 0x3000 plus a miss to 0x3000 → single fill, no reallocation. A response coincident with restore_valid → no fill.
- Reset mid-flight with 3 issued entries → all outputs at reset values next cycle; stale resp tags are ignored.
